// File: rtl/segment_rx_monitor_if.sv
// Bundle of the seven-segment loopback lines and the decoded status outputs.
// master drives the segment lines; slave is the monitor that decodes them.
interface segment_rx_monitor_if;
  logic [6:0] i_Segment_N;
  logic [3:0] o_Digit;
  logic       o_Valid;
  logic       o_Pattern_Err;
  logic       o_Seq_Err;
  logic       o_Blank;
  logic [7:0] o_Err_Count;

  modport master (
    output i_Segment_N,
    input  o_Digit, o_Valid, o_Pattern_Err, o_Seq_Err, o_Blank, o_Err_Count
  );

  modport slave (
    input  i_Segment_N,
    output o_Digit, o_Valid, o_Pattern_Err, o_Seq_Err, o_Blank, o_Err_Count
  );
endinterface

// File: rtl/segment_rx_monitor.sv
// Seven-segment receive checker: synchronizes, debounces and decodes the active-low glyph.
// Optional sequence checking is compiled in with `define SEG_RX_SEQ_CHECK_EN.
module segment_rx_monitor #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  segment_rx_monitor_if.slave  seg_bus
);

  localparam int              CNT_W     = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]      BLANK_PAT = 7'h7F;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_SETTLING,
    ST_LOCKED
  } state_t;

  state_t           state_reg, state_next;
  logic [6:0]       sync1_reg, sync2_reg;
  logic [6:0]       cand_reg, cand_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       digit_reg, digit_next;
  logic             valid_reg, valid_next;
  logic             perr_reg, perr_next;
  logic             blank_reg, blank_next;
  logic [7:0]       err_cnt_reg, err_cnt_next;
  logic             err_fire;
  logic [4:0]       decoded;

  // Returns {legal, value}; both accepted forms of 9 map to the same value.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    case (pat)
      7'h01:   decode_glyph = {1'b1, 4'h0};
      7'h4F:   decode_glyph = {1'b1, 4'h1};
      7'h12:   decode_glyph = {1'b1, 4'h2};
      7'h06:   decode_glyph = {1'b1, 4'h3};
      7'h4C:   decode_glyph = {1'b1, 4'h4};
      7'h24:   decode_glyph = {1'b1, 4'h5};
      7'h20:   decode_glyph = {1'b1, 4'h6};
      7'h0F:   decode_glyph = {1'b1, 4'h7};
      7'h00:   decode_glyph = {1'b1, 4'h8};
      7'h04:   decode_glyph = {1'b1, 4'h9};
      7'h0C:   decode_glyph = {1'b1, 4'h9};
      7'h08:   decode_glyph = {1'b1, 4'hA};
      7'h60:   decode_glyph = {1'b1, 4'hB};
      7'h31:   decode_glyph = {1'b1, 4'hC};
      7'h42:   decode_glyph = {1'b1, 4'hD};
      7'h30:   decode_glyph = {1'b1, 4'hE};
      7'h38:   decode_glyph = {1'b1, 4'hF};
      default: decode_glyph = 5'b0;
    endcase
  endfunction

`ifdef SEG_RX_SEQ_CHECK_EN
  logic       serr_reg, serr_next;
  logic       hist_valid_reg, hist_valid_next;
  logic [3:0] prev_reg, prev_next;
  logic [3:0] expect_digit;

  assign expect_digit = (prev_reg == 4'd9) ? 4'd0 : prev_reg + 4'd1;
`endif

  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    cnt_next     = cnt_reg;
    digit_next   = digit_reg;
    valid_next   = 1'b0;
    perr_next    = 1'b0;
    blank_next   = blank_reg;
    err_cnt_next = err_cnt_reg;
    decoded      = decode_glyph(cand_reg);
`ifdef SEG_RX_SEQ_CHECK_EN
    serr_next       = 1'b0;
    hist_valid_next = hist_valid_reg;
    prev_next       = prev_reg;
`endif

    // A change always wins, even on the cycle the count would have terminated.
    if (sync2_reg != cand_reg) begin
      cand_next  = sync2_reg;
      cnt_next   = '0;
      state_next = ST_SETTLING;
      blank_next = 1'b0;
    end else if (state_reg != ST_LOCKED) begin
      if (cnt_reg == CNT_LAST) begin
        state_next = ST_LOCKED;
        if (cand_reg == BLANK_PAT) begin
          blank_next = 1'b1;
`ifdef SEG_RX_SEQ_CHECK_EN
          hist_valid_next = 1'b0;
`endif
        end else if (decoded[4]) begin
          digit_next = decoded[3:0];
          valid_next = 1'b1;
`ifdef SEG_RX_SEQ_CHECK_EN
          if (hist_valid_reg && (decoded[3:0] != expect_digit)) begin
            serr_next = 1'b1;
          end
          prev_next       = decoded[3:0];
          hist_valid_next = 1'b1;
`endif
        end else begin
          perr_next = 1'b1;
        end
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end

`ifdef SEG_RX_SEQ_CHECK_EN
    err_fire = perr_next | serr_next;
`else
    err_fire = perr_next;
`endif
    if (err_fire && (err_cnt_reg != 8'hFF)) begin
      err_cnt_next = err_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg   <= ST_UNLOCKED;
      sync1_reg   <= BLANK_PAT;
      sync2_reg   <= BLANK_PAT;
      cand_reg    <= BLANK_PAT;
      cnt_reg     <= '0;
      digit_reg   <= 4'd0;
      valid_reg   <= 1'b0;
      perr_reg    <= 1'b0;
      blank_reg   <= 1'b0;
      err_cnt_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      sync1_reg   <= seg_bus.i_Segment_N;
      sync2_reg   <= sync1_reg;
      cand_reg    <= cand_next;
      cnt_reg     <= cnt_next;
      digit_reg   <= digit_next;
      valid_reg   <= valid_next;
      perr_reg    <= perr_next;
      blank_reg   <= blank_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

`ifdef SEG_RX_SEQ_CHECK_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      serr_reg       <= 1'b0;
      hist_valid_reg <= 1'b0;
      prev_reg       <= 4'd0;
    end else begin
      serr_reg       <= serr_next;
      hist_valid_reg <= hist_valid_next;
      prev_reg       <= prev_next;
    end
  end

  assign seg_bus.o_Seq_Err = serr_reg;
`else
  assign seg_bus.o_Seq_Err = 1'b0;
`endif

  assign seg_bus.o_Digit       = digit_reg;
  assign seg_bus.o_Valid       = valid_reg;
  assign seg_bus.o_Pattern_Err = perr_reg;
  assign seg_bus.o_Blank       = blank_reg;
  assign seg_bus.o_Err_Count   = err_cnt_reg;

endmodule

// File: tb/tb_segment_rx_monitor.sv
// Randomized bench for segment_rx_monitor: glyphs are built from segment-letter strings and
// outcomes predicted from the settle-window rule over the recorded input history.
module tb_segment_rx_monitor;
  localparam int         STABLE    = 4;
  localparam int         MAXC      = 16384;
  localparam logic [6:0] BLANK_PAT = 7'h7F;
`ifdef SEG_RX_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  segment_rx_monitor_if bus ();

  segment_rx_monitor #(.STABLE_CYCLES(STABLE)) dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .seg_bus (bus)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  logic [6:0] in_h    [MAXC];
  logic [6:0] yy_h    [MAXC];
  bit         rst_h   [MAXC];
  bit         start_h [MAXC];

  string      glyph_str [17];
  int         glyph_val [17];
  logic [6:0] glyph_pat [17];

  int m_digit, m_valid, m_perr, m_serr, m_blank, m_errc, m_prev;
  bit m_hist;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs != exp) begin
      n_mismatched++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_pattern(input string lit);
    logic [6:0] p;
    p = 7'h7F;
    for (int i = 0; i < lit.len(); i++) begin
      p[6 - (int'(lit[i]) - 65)] = 1'b0;
    end
    return p;
  endfunction

  // Outcome of the edge with index k, from the input/reset history recorded so far.
  task automatic model_edge(input int k);
    bit fire;
    bit found;
    int s, v, succ;
    logic [6:0] p;
    yy_h[k] = (k < 2 || rst_h[k] || rst_h[k-1] || rst_h[k-2]) ? BLANK_PAT : in_h[k-2];
    start_h[k] = rst_h[k] || (k >= 1 && yy_h[k] != yy_h[k-1]);
    if (rst_h[k]) begin
      m_digit = 0; m_valid = 0; m_perr = 0; m_serr = 0; m_blank = 0; m_errc = 0;
      m_hist = 1'b0; m_prev = 0;
      return;
    end
    m_valid = 0; m_perr = 0; m_serr = 0;
    if (start_h[k]) m_blank = 0;
    s = k - STABLE;
    fire = (s >= 0) && start_h[s];
    if (fire) begin
      for (int j = s + 1; j <= k; j++) begin
        if (yy_h[j] != yy_h[s] || rst_h[j]) fire = 1'b0;
      end
    end
    if (!fire) return;
    p = yy_h[k];
    found = 1'b0;
    v = 0;
    for (int i = 0; i < 17; i++) begin
      if (glyph_pat[i] == p) begin
        found = 1'b1;
        v = glyph_val[i];
      end
    end
    if (p == BLANK_PAT) begin
      m_blank = 1;
      m_hist = 1'b0;
      $display("[%0d] pattern %02h -> blank", k, p);
    end else if (found) begin
      m_digit = v;
      m_valid = 1;
      succ = (m_prev == 9) ? 0 : ((m_prev + 1) % 16);
      if (SEQ_ON && m_hist && v != succ) m_serr = 1;
      m_prev = v;
      m_hist = 1'b1;
      $display("[%0d] pattern %02h -> digit %0h seq_err=%0d", k, p, v, m_serr);
    end else begin
      m_perr = 1;
      $display("[%0d] pattern %02h -> illegal glyph", k, p);
    end
    if ((m_perr != 0 || m_serr != 0) && m_errc < 255) m_errc++;
  endtask

  task automatic step();
    @(posedge clk);
    if (cyc >= MAXC) begin
      n_mismatched++;
      $display("FAIL cycle_budget cycle=%0d got=exhausted expected=below %0d", cyc, MAXC);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
    end
    in_h[cyc]  = bus.i_Segment_N;
    rst_h[cyc] = rst;
    model_edge(cyc);
    cyc++;
    @(negedge clk);
    check_val("valid",    int'(bus.o_Valid),       m_valid);
    check_val("pat_err",  int'(bus.o_Pattern_Err), m_perr);
    check_val("seq_err",  int'(bus.o_Seq_Err),     m_serr);
    check_val("blank",    int'(bus.o_Blank),       m_blank);
    check_val("digit",    int'(bus.o_Digit),       m_digit);
    check_val("err_cnt",  int'(bus.o_Err_Count),   m_errc);
  endtask

  task automatic wait_valid(output int n);
    n = 99;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (bus.o_Valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic hold(input logic [6:0] p, input int cycles);
    bus.i_Segment_N = p;
    repeat (cycles) step();
  endtask

  initial begin
    int lat, sel, len, last_v, idx;
    logic [6:0] p;

    glyph_str = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG", "ABC",
                  "ABCDEFG", "ABCDFG", "ABCFG", "ABCEFG", "CDEFG", "ADEF", "BCDEG",
                  "ADEFG", "AEFG"};
    glyph_val = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 10, 11, 12, 13, 14, 15};
    for (int i = 0; i < 17; i++) glyph_pat[i] = seg_pattern(glyph_str[i]);

    bus.i_Segment_N = BLANK_PAT;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check_val("reset_blank_level", int'(bus.o_Blank), 1);

    bus.i_Segment_N = seg_pattern("ABCDEF");
    wait_valid(lat);
    check_val("basic_latency", lat, 7);
    check_val("basic_digit", int'(bus.o_Digit), 0);
    repeat (6) step();

    hold(seg_pattern("BC"), 3);
    hold(seg_pattern("ABCDEF"), 12);

    bus.i_Segment_N = BLANK_PAT;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    hold(seg_pattern("ABCDEFG"), 10);
    hold(seg_pattern("ABCFG"), 10);
    hold(seg_pattern("ABCDEF"), 10);
    hold(seg_pattern("ABDEG"), 10);
    check_val("seq_err_count", int'(bus.o_Err_Count), SEQ_ON ? 1 : 0);

    hold(7'h3F, 10);
    check_val("illegal_digit_hold", int'(bus.o_Digit), 2);
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h3E : 7'h3F, 6);
    check_val("err_count_saturated", int'(bus.o_Err_Count), 255);

    hold(seg_pattern("ACDFG"), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_valid(lat);
    check_val("midsettle_latency", lat, 7);
    check_val("midsettle_digit", int'(bus.o_Digit), 5);
    repeat (4) step();

    last_v = 5;
    for (int it = 0; it < 350; it++) begin
      sel = $urandom_range(99, 0);
      if (sel < 35) begin
        last_v = (last_v + 1) % 10;
        idx = (last_v == 9) ? $urandom_range(10, 9) : last_v;
        p = glyph_pat[idx];
      end else if (sel < 65) begin
        idx = $urandom_range(16, 0);
        p = glyph_pat[idx];
        last_v = glyph_val[idx] % 10;
      end else if (sel < 78) begin
        p = BLANK_PAT;
      end else begin
        p = 7'($urandom_range(127, 0));
      end
      len = $urandom_range(10, 1);
      if ($urandom_range(49, 0) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      hold(p, len);
    end
    hold(BLANK_PAT, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/segment_rx_monitor.md
# segment_rx_monitor

Receive-side checker for the board's active-low seven-segment digit drive. It samples the seven segment lines, waits for a stable pattern, and decodes it back to a 4-bit value. It also flags illegal glyphs and, optionally, counts that break the 0–9 wrap-around sequence. It sits in loopback against the switch-driven digit counter and is used for self-test on the board and in simulation.

## Interface
- STABLE_CYCLES, 4, cycles a synchronized pattern must hold unchanged before it is decoded (≥2; board builds use 250000).
- i_Clk  in  1  system clock; all logic is on its rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Segment_N  in  7  active-low segment lines: bit6=A, bit5=B, bit4=C, bit3=D, bit2=E, bit1=F, bit0=G. A 0 means the segment is lit.
- o_Digit  out  4  last successfully decoded value, 0x0–0xF.
- o_Valid  out  1  one-cycle strobe; a new legal glyph was decoded.
- o_Pattern_Err  out  1  one-cycle strobe; a stable pattern is not a legal glyph.
- o_Seq_Err  out  1  one-cycle strobe; a legal digit is not the successor of the previous one.
- o_Blank  out  1  level; the stable pattern has all segments off (7'h7F).
- o_Err_Count  out  8  saturating count of o_Pattern_Err plus o_Seq_Err strobes.

## Operation
- **Input synchronizer.** 2-flop synchronizer on i_Segment_N. Its output (s2) feeds a candidate register `cand` and a stability counter `cnt` of width clog2(STABLE_CYCLES).
- **States.** UNLOCKED (after reset), SETTLING, LOCKED.
  - Any cycle with s2 ≠ cand: cand←s2, cnt←0, go to SETTLING. This applies from every state.
  - SETTLING with s2 = cand: cnt increments. When cnt = STABLE_CYCLES−1, decode cand, go to LOCKED, and emit the strobes for that cycle.
  - LOCKED with s2 = cand: hold; no further strobes.
- **Glyph table** (lit segments):
  - 0=ABCDEF, 1=BC, 2=ABDEG, 3=ABCDG, 4=BCFG, 5=ACDFG, 6=ACDEFG, 7=ABC, 8=ABCDEFG.
  - 9=ABCDFG, or ABCFG (both accepted).
  - A=ABCEFG, b=CDEFG, C=ADEF, d=BCDEG, E=ADEFG, F=AEFG.
- **Decode outcomes.**
  - Legal glyph: o_Digit←value, o_Valid=1.
  - All off: o_Blank=1 and no o_Valid. The previous-digit history is cleared, so the next digit is not sequence-checked.
  - Anything else: o_Pattern_Err=1. o_Digit and the history are unchanged.
- **Sequence rule.** Checked only when a history is held. Expected digit = (prev=9) ? 0 : prev+1. Any other legal value, including 0xA–0xF, gives o_Seq_Err=1 in the same cycle as o_Valid. prev←new value in either case.
- **o_Err_Count.** Adds 1 for each error strobe. Both error strobes cannot fire in the same cycle. Saturates at 255.
- **o_Blank.** Cleared on the cycle the state machine leaves LOCKED.

## Timing
- **Reset values.** o_Digit=0, o_Valid=0, o_Pattern_Err=0, o_Seq_Err=0, o_Blank=0, o_Err_Count=0. State=UNLOCKED, history invalid, cand=7'h7F, synchronizer flops=7'h7F.
- **Latency.** An input change that then holds steady produces its strobe exactly STABLE_CYCLES+3 cycles after the input edge.
- **Simultaneous events.** If s2 changes on the cycle cnt would reach terminal, the change wins: cnt restarts and no strobe is emitted.
- **Reset mid-settle.** Reset asserted mid-SETTLING aborts decode with no strobe. The pattern must then re-settle fully after reset.
- **Glitches.** A glitch shorter than STABLE_CYCLES produces no strobe. If the input returns to the original LOCKED pattern, that pattern re-settles and is reported again; o_Seq_Err fires if sequence checking is enabled.

## Configuration
- **SEG_RX_SEQ_CHECK_EN defined:** sequence rule, history tracking and o_Seq_Err are active.
- **SEG_RX_SEQ_CHECK_EN undefined:**
  - o_Seq_Err is tied to 0 and history logic is removed.
  - o_Err_Count counts pattern errors only.
  - All other behaviour is identical.

## Test plan
All scenarios use STABLE_CYCLES=4 and SEG_RX_SEQ_CHECK_EN defined unless stated.
- **Reset check.** Hold i_Rst for 3 cycles, input 7'h7F → all outputs 0; no strobe for 20 cycles after release except a single o_Blank level.
- **Basic decode.** Drive 7'h01 ("0") at cycle t → o_Valid=1 and o_Digit=0 exactly at t+7, one cycle wide; o_Seq_Err=0.
- **Glitch rejection.** "0" locked, then "1" (7'h4F) for 3 cycles, then back to "0" → no o_Valid for "1"; "0" is re-reported.
- **Sequence check.** Sequence 8, 9 (ABCFG form), 0 → three o_Valid, no o_Seq_Err. Then 2 → o_Seq_Err=1, o_Err_Count=1. Repeat with the macro undefined → o_Seq_Err stays 0.
- **Illegal glyph.** Pattern with only A lit (7'h3F) → o_Pattern_Err=1, o_Digit holds the previous value, o_Err_Count increments. 300 such errors → o_Err_Count saturates at 255.
- **Reset mid-settle.** Reset on the 3rd settling cycle of "5" → no strobe; after release, "5" decodes 7 cycles later with no o_Seq_Err.
